// File: rtl/adder8_pkg.sv
// -----------------------------------------------------------------------------
// adder8_pkg
//   Shared constants and types for the pipelined 8-bit adder.
//   WIDTH  : operand / sum width
//   STAGES : pipeline depth, one carry-chain slice per stage
//   SLICE  : bits summed per stage (WIDTH / STAGES)
//   operand_t / slice_t : convenience vector types for operands and slices
//   Optional feature macro used by the top level: ADDER8_VALID_EN
// -----------------------------------------------------------------------------
package adder8_pkg;

  localparam int WIDTH  = 8;
  localparam int STAGES = 4;
  localparam int SLICE  = WIDTH / STAGES;

  typedef logic [WIDTH-1:0] operand_t;
  typedef logic [SLICE-1:0] slice_t;

endpackage : adder8_pkg

// File: rtl/adder8_4_pipeline_slice.sv
// -----------------------------------------------------------------------------
// adder_slice
//   Purely combinational W-bit adder with carry-in: {co, s} = a + b + ci.
//   One instance per pipeline stage; the registers live in the top level.
//   Ports:
//     a, b : W-bit operand slices
//     ci   : carry from the previous slice (or the adder carry-in)
//     s    : W-bit slice sum
//     co   : carry out of this slice
// -----------------------------------------------------------------------------
module adder_slice
  import adder8_pkg::*;
#(
  parameter int W = SLICE
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  // Operands are zero-extended by one bit so the carry out is captured.
  always_comb begin
    {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
  end

endmodule : adder_slice

// File: rtl/adder8_4_pipeline.sv
// -----------------------------------------------------------------------------
// adder8_4_pipeline
//   8-bit adder with carry-in whose carry chain is cut into STAGES registered
//   slices of SLICE bits. One operand set is accepted every clock and its
//   result appears on {cout, sum} after the 4th rising edge (edges k..k+3).
//   Ports:
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset, clears every pipeline register
//     ain    : operand A (WIDTH bits), sampled every rising edge
//     bin    : operand B (WIDTH bits), sampled every rising edge
//     cin    : carry-in, sampled with ain/bin
//     sum    : registered (ain + bin + cin)[WIDTH-1:0]
//     cout   : registered carry-out, bit WIDTH of ain + bin + cin
//     vin    : (ADDER8_VALID_EN only) valid flag travelling with the operands
//     vout   : (ADDER8_VALID_EN only) vin delayed by the pipeline latency
//   Configuration macro: ADDER8_VALID_EN adds the vin/vout valid pipeline.
//
//   Stage s register contents:
//     psum_q    : all partial sums computed so far, lower slices included,
//                 so that slices of one operand set stay aligned
//     carry_q   : carry out of slice s
//     a/b_rem_q : operand bits not yet added (absent in the last stage)
// -----------------------------------------------------------------------------
module adder8_4_pipeline #(
  parameter int WIDTH  = adder8_pkg::WIDTH,
  parameter int STAGES = adder8_pkg::STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
`ifdef ADDER8_VALID_EN
  output logic             cout,
  input  logic             vin,
  output logic             vout
`else
  output logic             cout
`endif
);

  // WIDTH must divide evenly by STAGES; not overridable on its own.
  localparam int SLICE = WIDTH / STAGES;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int LO  = s * SLICE;      // bits already summed before stage s
    localparam int REM = WIDTH - LO;     // operand bits still unadded entering stage s

    logic [REM-1:0]        a_in;
    logic [REM-1:0]        b_in;
    logic                  carry_in;
    logic [SLICE-1:0]      slice_sum;
    logic                  slice_co;
    logic [LO+SLICE-1:0]   psum_d;
    logic [LO+SLICE-1:0]   psum_q;
    logic                  carry_d;
    logic                  carry_q;

    if (s == 0) begin : g_head
      // First stage works directly on the ports and the external carry-in.
      always_comb begin
        a_in     = ain;
        b_in     = bin;
        carry_in = cin;
        psum_d   = slice_sum;
      end
    end else begin : g_body
      // Later stages take the remaining operand bits and the carry of the
      // previous stage, and append their slice above the aligned lower sums.
      always_comb begin
        a_in     = g_stage[s-1].g_rem.a_rem_q;
        b_in     = g_stage[s-1].g_rem.b_rem_q;
        carry_in = g_stage[s-1].carry_q;
        psum_d   = {slice_sum, g_stage[s-1].psum_q};
      end
    end

    adder_slice #(
      .W (SLICE)
    ) u_slice (
      .a  (a_in[SLICE-1:0]),
      .b  (b_in[SLICE-1:0]),
      .ci (carry_in),
      .s  (slice_sum),
      .co (slice_co)
    );

    always_comb begin
      carry_d = slice_co;
    end

    // NOTE: state updates use non-blocking assignments and the reset is in the
    // sensitivity list, so every stage samples the previous stage's old value
    // and clears immediately when rst_n falls, not at the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        psum_q  <= '0;
        carry_q <= 1'b0;
      end else begin
        psum_q  <= psum_d;
        carry_q <= carry_d;
      end
    end

    // Upper operand bits ride along until their slice is reached; the last
    // stage has nothing left to carry forward.
    if (s < STAGES - 1) begin : g_rem
      logic [REM-SLICE-1:0] a_rem_d;
      logic [REM-SLICE-1:0] a_rem_q;
      logic [REM-SLICE-1:0] b_rem_d;
      logic [REM-SLICE-1:0] b_rem_q;

      always_comb begin
        a_rem_d = a_in[REM-1:SLICE];
        b_rem_d = b_in[REM-1:SLICE];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_rem_q <= '0;
          b_rem_q <= '0;
        end else begin
          a_rem_q <= a_rem_d;
          b_rem_q <= b_rem_d;
        end
      end
    end
  end

  // Both outputs come straight from the last stage's registers.
  always_comb begin
    sum  = g_stage[STAGES-1].psum_q;
    cout = g_stage[STAGES-1].carry_q;
  end

`ifdef ADDER8_VALID_EN
  // Valid flag shift register with the same depth as the data path.
  logic [STAGES-1:0] vld_d;
  logic [STAGES-1:0] vld_q;

  always_comb begin
    vld_d = {vld_q[STAGES-2:0], vin};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  always_comb begin
    vout = vld_q[STAGES-1];
  end
`endif

endmodule : adder8_4_pipeline

// File: tb/tb_adder8_4_pipeline.sv
// -----------------------------------------------------------------------------
// tb_adder8_4_pipeline
//   Self-checking bench for adder8_4_pipeline. The reference is a 4-deep delay
//   line of full-precision sums ain + bin + cin (plus vin when the valid
//   feature is built in); the DUT output must equal the oldest entry.
//   Build with +define+ADDER8_VALID_EN to exercise vin/vout as well.
// -----------------------------------------------------------------------------
module tb_adder8_4_pipeline;

  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] ain = 8'h00;
  logic [7:0] bin = 8'h00;
  logic       cin = 1'b0;
  logic [7:0] sum;
  logic       cout;
`ifdef ADDER8_VALID_EN
  logic       vin = 1'b0;
  logic       vout;
`endif

  int passed = 0;
  int total  = 0;

  logic [8:0] ref_sum [LAT];
  logic       ref_vld [LAT];

  adder8_4_pipeline dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ain   (ain),
    .bin   (bin),
    .cin   (cin),
    .sum   (sum),
`ifdef ADDER8_VALID_EN
    .cout  (cout),
    .vin   (vin),
    .vout  (vout)
`else
    .cout  (cout)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Compare the DUT against the oldest entry of the reference delay line.
  task automatic check_out(input string tag);
    check(tag, {cout, sum}, ref_sum[LAT-1]);
`ifdef ADDER8_VALID_EN
    check({tag, "_vout"}, {8'h00, vout}, {8'h00, ref_vld[LAT-1]});
`endif
  endtask

  task automatic ref_clear();
    for (int i = 0; i < LAT; i++) begin
      ref_sum[i] = 9'h000;
      ref_vld[i] = 1'b0;
    end
  endtask

  // Present one operand set, take one rising edge, then check #1 later.
  task automatic step(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic v, input string tag);
    ain = a;
    bin = b;
    cin = c;
`ifdef ADDER8_VALID_EN
    vin = v;
`endif
    @(posedge clk);
    if (rst_n) begin
      for (int i = LAT - 1; i > 0; i--) begin
        ref_sum[i] = ref_sum[i-1];
        ref_vld[i] = ref_vld[i-1];
      end
      ref_sum[0] = 9'(a) + 9'(b) + 9'(c);
      ref_vld[0] = v;
    end
    #1;
    check_out(tag);
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;

    ref_clear();

    // 1. Reset held with random inputs; check after each edge and mid-cycle.
    #1 rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(8'($urandom), 8'($urandom), 1'($urandom), 1'b1, "rst_hold");
      #3;
      check_out("rst_mid");
      #2;
    end
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 2. Full carry ripple through every slice.
    step(8'hFF, 8'h01, 1'b0, 1'b1, "t2_in");
    for (int i = 0; i < 3; i++) step(8'h00, 8'h00, 1'b0, 1'b0, "t2_wait");
    check("t2_ripple", {cout, sum}, 9'h100);

    // 3. Alternating bits with carry-in, then a single mid-chain ripple.
    step(8'h55, 8'hAA, 1'b1, 1'b1, "t3_in0");
    step(8'h7F, 8'h01, 1'b0, 1'b1, "t3_in1");
    step(8'h00, 8'h00, 1'b0, 1'b0, "t3_wait");
    step(8'h00, 8'h00, 1'b0, 1'b0, "t3_wait");
    check("t3_alt", {cout, sum}, 9'h100);
    step(8'h00, 8'h00, 1'b0, 1'b0, "t3_wait");
    check("t3_7f", {cout, sum}, 9'h080);

    // 4. Back-to-back stream, results on consecutive cycles.
    step(8'h01, 8'h01, 1'b0, 1'b1, "t4_in0");
    step(8'h02, 8'h02, 1'b1, 1'b1, "t4_in1");
    step(8'hFF, 8'hFF, 1'b1, 1'b1, "t4_in2");
    step(8'h00, 8'h00, 1'b0, 1'b0, "t4_wait");
    check("t4_r0", {cout, sum}, 9'h002);
    step(8'h00, 8'h00, 1'b0, 1'b0, "t4_wait");
    check("t4_r1", {cout, sum}, 9'h005);
    step(8'h00, 8'h00, 1'b0, 1'b0, "t4_wait");
    check("t4_r2", {cout, sum}, 9'h1FF);

    // 5. Reset mid-cycle with three non-zero results in flight.
    for (int i = 0; i < 3; i++) begin
      ra = 8'($urandom) | 8'h01;
      rb = 8'($urandom) | 8'h01;
      step(ra, rb, 1'b1, 1'b1, "t5_fill");
    end
    #3 rst_n = 1'b0;
    ref_clear();
    #1;
    check("t5_rst_now", {cout, sum}, 9'h000);
    #1;
    step(8'hC3, 8'h3C, 1'b1, 1'b1, "t5_hold");
    step(8'hA5, 8'h5A, 1'b0, 1'b1, "t5_hold");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ra = 8'($urandom) | 8'h01;
      rb = 8'($urandom) | 8'h01;
      step(ra, rb, 1'b0, 1'b1, "t5_post");
    end
    check("t5_no_ghost", {cout, sum}, 9'h000);
    step(8'h00, 8'h00, 1'b0, 1'b0, "t5_first");

    // 6. Random stream, a new vector every clock.
    for (int i = 0; i < 10000; i++) begin
      step(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), "t6_rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_adder8_4_pipeline
